// File: rtl/match_collector_if.sv
// Output stream of the match collector toward the host DMA.
// FWFT valid/ready: data is held while ready is low.
interface match_collector_if #(
  parameter int ID_WIDTH = 16
);
  logic [2*ID_WIDTH-1:0] o_Data;
  logic                  o_Valid;
  logic                  i_Ready;

  modport master (
    output o_Data,
    output o_Valid,
    input  i_Ready
  );

  modport slave (
    input  o_Data,
    input  o_Valid,
    output i_Ready
  );
endinterface

// File: rtl/match_collector.sv
// Buffers matching ID pairs from the Tanimoto comparator
// in a FWFT FIFO and tracks batch progress and statistics.
module match_collector #(
  parameter int ID_WIDTH   = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic                  i_Valid,
  input  logic                  i_Match,
  input  logic                  i_Last,
  input  logic [ID_WIDTH-1:0]   i_IdA,
  input  logic [ID_WIDTH-1:0]   i_IdB,
  match_collector_if.master     out_if,
  output logic [STAT_WIDTH-1:0] o_MatchCnt,
  output logic [STAT_WIDTH-1:0] o_DropCnt,
  output logic                  o_Overflow,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [2*ID_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] rd_nxt;

  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push_ok;
  logic drop;
  logic last_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = !empty && out_if.i_Ready;
  assign push_req = (state == COLLECT) && i_Valid && i_Match;
  // A full FIFO still takes the push if a slot frees this cycle
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign rd_nxt   = rd_ptr + 1'b1;
  assign last_pop = pop && (rd_nxt == wr_ptr);

  assign out_if.o_Valid = !empty;
  assign out_if.o_Data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign o_Busy = (state == COLLECT) || (state == DRAIN);
  assign o_Done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {i_IdA, i_IdB};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_MatchCnt <= '0;
      o_DropCnt  <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr     <= wr_ptr + 1'b1;
        o_MatchCnt <= o_MatchCnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      if (drop) begin
        o_DropCnt  <= o_DropCnt + 1'b1;
        o_Overflow <= 1'b1;
      end

      unique case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            state      <= COLLECT;
            o_MatchCnt <= '0;
            o_DropCnt  <= '0;
            o_Overflow <= 1'b0;
          end
        end
        COLLECT: begin
          if (i_Valid && i_Last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty || last_pop) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_collector.sv
// Directed and random stimulus for match_collector,
// checked against a queue-based reference model.
module tb_match_collector;

  localparam int IW = 16;
  localparam int D  = 4;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_Start;
  logic          i_Valid;
  logic          i_Match;
  logic          i_Last;
  logic [IW-1:0] i_IdA;
  logic [IW-1:0] i_IdB;
  logic [SW-1:0] o_MatchCnt;
  logic [SW-1:0] o_DropCnt;
  logic          o_Overflow;
  logic          o_Busy;
  logic          o_Done;

  match_collector_if #(.ID_WIDTH(IW)) m_if ();

  match_collector #(
    .ID_WIDTH  (IW),
    .FIFO_DEPTH(D),
    .STAT_WIDTH(SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_Start   (i_Start),
    .i_Valid   (i_Valid),
    .i_Match   (i_Match),
    .i_Last    (i_Last),
    .i_IdA     (i_IdA),
    .i_IdB     (i_IdB),
    .out_if    (m_if.master),
    .o_MatchCnt(o_MatchCnt),
    .o_DropCnt (o_DropCnt),
    .o_Overflow(o_Overflow),
    .o_Busy    (o_Busy),
    .o_Done    (o_Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 collect, 2 drain, 3 done
  int            ms;
  logic [2*IW-1:0] mq[$];
  logic [2*IW-1:0] got[$];
  logic [SW-1:0] mmc;
  logic [SW-1:0] mdc;
  logic          movf;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2*IW-1:0] ed;
    ed = (mq.size() != 0) ? mq[0] : '0;
    chk("valid", {63'd0, m_if.o_Valid},
        {63'd0, mq.size() != 0});
    chk("data", {32'd0, m_if.o_Data}, {32'd0, ed});
    chk("match_cnt", {32'd0, o_MatchCnt}, {32'd0, mmc});
    chk("drop_cnt", {32'd0, o_DropCnt}, {32'd0, mdc});
    chk("overflow", {63'd0, o_Overflow}, {63'd0, movf});
    chk("busy", {63'd0, o_Busy},
        {63'd0, ms == 1 || ms == 2});
    chk("done", {63'd0, o_Done}, {63'd0, ms == 3});
  endtask

  task automatic tick(input logic s, input logic v,
                      input logic m, input logic l,
                      input logic [IW-1:0] a,
                      input logic [IW-1:0] b,
                      input logic r,
                      input logic rs = 1'b0);
    bit pop;
    bit preq;
    int n;
    rst          = rs;
    i_Start      = s;
    i_Valid      = v;
    i_Match      = m;
    i_Last       = l;
    i_IdA        = a;
    i_IdB        = b;
    m_if.i_Ready = r;
    n    = mq.size();
    pop  = (n != 0) && r && !rs;
    preq = (ms == 1) && v && m;
    if (pop) got.push_back(m_if.o_Data);
    @(posedge clk);
    if (rs) begin
      ms   = 0;
      mq.delete();
      mmc  = '0;
      mdc  = '0;
      movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (preq) begin
        if (n < D || pop) begin
          mq.push_back({a, b});
          mmc++;
        end else begin
          mdc++;
          movf = 1'b1;
        end
      end
      case (ms)
        0, 3: if (s) begin
          ms   = 1;
          mmc  = '0;
          mdc  = '0;
          movf = 1'b0;
        end
        1: if (v && l) ms = 2;
        2: if (mq.size() == 0) ms = 3;
        default: ms = 0;
      endcase
    end
    #1;
    check_all();
  endtask

  task automatic idle(input logic r);
    tick(0, 0, 0, 0, '0, '0, r);
  endtask

  task automatic start();
    got.delete();
    tick(1, 0, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && ms != 3; i++) idle(1'b1);
    chk("drain_done", {63'd0, o_Done}, 64'd1);
  endtask

  task automatic chk_got(input string tag,
                         input logic [IW-1:0] a,
                         input int b0, input int cnt);
    chk({tag, "_n"}, 64'(got.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < got.size(); i++)
      chk(tag, {32'd0, got[i]},
          {32'd0, a, 16'(b0 + i)});
  endtask

  initial begin
    logic [IW-1:0] ids[5];
    bit mpat[8];
    ms   = 0;
    mmc  = '0;
    mdc  = '0;
    movf = 1'b0;

    // reset state
    tick(0, 0, 0, 0, '0, '0, 1'b0, 1'b1);
    tick(0, 1, 1, 0, 16'd1, 16'd2, 1'b0, 1'b1);
    chk("rst_valid", {63'd0, m_if.o_Valid}, 64'd0);
    chk("rst_data", {32'd0, m_if.o_Data}, 64'd0);

    // basic batch, mixed match pattern
    mpat = '{1, 0, 1, 1, 0, 0, 1, 1};
    start();
    for (int i = 0; i < 8; i++)
      tick(0, 1, mpat[i], i == 7, 16'd5,
           16'(100 + i), 1'b1);
    drain();
    ids = '{16'd100, 16'd102, 16'd103, 16'd106, 16'd107};
    chk("t1_n", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("t1_order", {32'd0, got[i]},
          {32'd0, 16'd5, ids[i]});
    chk("t1_mcnt", {32'd0, o_MatchCnt}, 64'd5);
    chk("t1_dcnt", {32'd0, o_DropCnt}, 64'd0);

    // overflow with backpressure
    start();
    for (int i = 0; i < 6; i++)
      tick(0, 1, 1, i == 5, 16'd7, 16'(i), 1'b0);
    chk("t2_mcnt", {32'd0, o_MatchCnt}, 64'd4);
    chk("t2_dcnt", {32'd0, o_DropCnt}, 64'd2);
    chk("t2_ovf", {63'd0, o_Overflow}, 64'd1);
    drain();
    chk_got("t2_order", 16'd7, 0, 4);

    // push into full FIFO while popping
    start();
    for (int i = 0; i < 4; i++)
      tick(0, 1, 1, 0, 16'd5, 16'(10 + i), 1'b0);
    tick(0, 1, 1, 1, 16'd5, 16'd14, 1'b1);
    chk("t3_dcnt", {32'd0, o_DropCnt}, 64'd0);
    chk("t3_mcnt", {32'd0, o_MatchCnt}, 64'd5);
    drain();
    chk_got("t3_order", 16'd5, 10, 5);

    // ready toggling 1,0,0,1
    start();
    for (int i = 0; i < 3; i++)
      tick(0, 1, 1, i == 2, 16'd5, 16'(20 + i), 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("t4_hold", {32'd0, m_if.o_Data},
        {32'd0, 16'd5, 16'd21});
    idle(1'b0);
    chk("t4_hold", {32'd0, m_if.o_Data},
        {32'd0, 16'd5, 16'd21});
    idle(1'b1);
    drain();
    chk_got("t4_order", 16'd5, 20, 3);

    // reset while draining
    start();
    for (int i = 0; i < 3; i++)
      tick(0, 1, 1, i == 2, 16'd9, 16'(i), 1'b0);
    chk("t5_busy", {63'd0, o_Busy}, 64'd1);
    tick(0, 0, 0, 0, '0, '0, 1'b0, 1'b1);
    chk("t5_valid", {63'd0, m_if.o_Valid}, 64'd0);
    chk("t5_busy0", {63'd0, o_Busy}, 64'd0);
    for (int i = 0; i < 3; i++)
      tick(0, 1, 1, i == 2, 16'd9, 16'(i), 1'b1);
    chk("t5_ign", {32'd0, o_MatchCnt}, 64'd0);

    // single non-matching last comparison
    start();
    tick(0, 1, 0, 1, 16'd1, 16'd1, 1'b1);
    chk("t6_drain", {63'd0, o_Busy}, 64'd1);
    idle(1'b1);
    chk("t6_done", {63'd0, o_Done}, 64'd1);
    chk("t6_mcnt", {32'd0, o_MatchCnt}, 64'd0);
    start();
    chk("t6_redone", {63'd0, o_Done}, 64'd0);
    tick(0, 1, 0, 1, '0, '0, 1'b1);
    drain();

    // random batches
    for (int bt = 0; bt < 30; bt++) begin
      int k;
      int nv;
      k  = $urandom_range(1, 24);
      nv = 0;
      start();
      for (int c = 0; c < 400 && nv < k; c++) begin
        logic v;
        v = ($urandom_range(0, 9) < 7);
        if (v) nv++;
        tick(($urandom_range(0, 7) == 0), v,
             $urandom_range(0, 1), v && nv == k,
             16'($urandom), 16'($urandom),
             $urandom_range(0, 2) != 0);
      end
      for (int c = 0; c < 60 && ms != 3; c++)
        tick(0, 1, 1, 0, 16'($urandom), 16'($urandom),
             $urandom_range(0, 1));
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/match_collector.md
Name: match_collector

Overview:
- Sits directly downstream of the Tanimoto threshold comparator.
- Accepts one match decision per cycle (comparator o_Dout/o_Valid), together with the pair of vector IDs aligned to that decision.
- Buffers the ID pairs of matching comparisons in an internal FWFT FIFO and streams them out over a valid/ready interface toward the host DMA.
- Tracks batch progress with a small FSM and keeps match/drop statistics.

Parameters:
- ID_WIDTH, 16, width of each vector ID (reference ID and database ID).
- FIFO_DEPTH, 64, number of buffered match entries; must be a power of two, minimum 4.
- STAT_WIDTH, 32, width of the match and drop counters.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous reset, active-high.
- i_Start  input  1  one-cycle pulse that begins a batch.
- i_Valid  input  1  comparison result valid (from comparator o_Valid).
- i_Match  input  1  comparison passed the threshold (from comparator o_Dout).
- i_Last  input  1  qualifies i_Valid; marks the final comparison of the batch.
- i_IdA  input  ID_WIDTH  reference vector ID aligned with i_Match.
- i_IdB  input  ID_WIDTH  database vector ID aligned with i_Match.
- o_Data  output  2*ID_WIDTH  output entry {IdA, IdB}; IdA occupies the MSBs.
- o_Valid  output  1  o_Data holds a valid entry.
- i_Ready  input  1  downstream accepts o_Data.
- o_MatchCnt  output  STAT_WIDTH  matches accepted into the FIFO this batch.
- o_DropCnt  output  STAT_WIDTH  matches lost because the FIFO was full.
- o_Overflow  output  1  sticky flag; set on the first drop in the batch.
- o_Busy  output  1  FSM is in COLLECT or DRAIN.
- o_Done  output  1  FSM is in DONE.

Behaviour:
- Reset values: FSM=IDLE, FIFO empty, o_Valid=0, o_Data=0, o_MatchCnt=0, o_DropCnt=0, o_Overflow=0, o_Busy=0, o_Done=0. Reset mid-batch discards all FIFO contents in the same cycle.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE or DONE: i_Start moves the FSM to COLLECT on the next edge and clears both counters and o_Overflow. The FIFO is already empty in these states. While in IDLE or DONE, i_Valid, i_Match and i_Last are ignored.
- COLLECT: each cycle where i_Valid=1 and i_Match=1 is a push request.
  - i_Valid=1 with i_Last=1 moves the FSM to DRAIN; that final comparison is still processed normally.
  - i_Start is ignored in COLLECT.
- DRAIN: no pushes are accepted. The FSM moves to DONE on the edge where the FIFO becomes empty, including the cycle the last entry is popped. If the FIFO is already empty on entry, the FSM reaches DONE one cycle after entering DRAIN. i_Start is ignored in DRAIN.
- Push rules:
  - If not full, write {i_IdA, i_IdB} and increment o_MatchCnt.
  - If full and no pop occurs in the same cycle, drop the entry, increment o_DropCnt and set o_Overflow.
  - If full and a pop occurs in the same cycle, the push is accepted and the occupancy stays unchanged.
  - Counters wrap at 2^STAT_WIDTH.
- Pop rule: a pop occurs when o_Valid=1 and i_Ready=1. o_Valid is the FIFO not-empty indicator. o_Data and o_Valid must stay stable while i_Ready=0.
- Latency: a push accepted on edge t makes the entry visible on o_Data/o_Valid after edge t, i.e. one cycle, when the FIFO was empty.
- Ordering: entries leave in strict arrival order.
- Pointers: read and write pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished at wrap-around.
- Simultaneous push and pop on an empty FIFO: the pop is invalid (o_Valid=0) and the push proceeds normally.
- Non-matching valid comparisons (i_Match=0) change no state, except i_Last handling.
- o_Busy and o_Done are decoded directly from the FSM state register.

Test Plan:
- Reset, then i_Start, then 8 valid comparisons with i_Match=1,0,1,1,0,0,1,1, IdA=5, IdB=100..107, i_Ready=1, i_Last on the 8th. Required: o_Data outputs {5,100},{5,102},{5,103},{5,106},{5,107} in order; o_MatchCnt=5; o_DropCnt=0; o_Done=1 one cycle after the last pop.
- FIFO_DEPTH=4, i_Ready=0, 6 consecutive matches with IdB=0..5. Required: o_MatchCnt=4, o_DropCnt=2, o_Overflow=1; raising i_Ready then yields IdB 0,1,2,3 only.
- FIFO full (4 entries), i_Ready=1 with a push in the same cycle. Required: push accepted, o_DropCnt stays 0, occupancy stays 4, and the new entry emerges after the original 4.
- Backpressure: toggle i_Ready 1,0,0,1 while 3 entries are queued. Required: o_Data is held unchanged during the i_Ready=0 cycles; no entry is duplicated or skipped.
- Assert rst while in DRAIN with 3 entries queued. Required: next cycle o_Valid=0, FSM=IDLE, counters=0; matches presented before the next i_Start are ignored.
- Batch containing a single valid comparison with i_Last=1 and i_Match=0. Required: FSM goes COLLECT→DRAIN→DONE in 2 cycles; o_MatchCnt=0. A subsequent i_Start clears counters and returns o_Done to 0.
